// File: rtl/fcl_divide_pkg.sv
// Shared definitions for the fcl_divide core and its requester arbiter:
// FSM state encodings, the zero-divide quotient pattern and clogb2.
package fcl_divide_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'b0001,
      ST_START = 4'b0010,
      ST_WAIT  = 4'b0100,
      ST_DONE  = 4'b1000
   } state_e;

   localparam int MAX_DATA_WIDTH = 128;

   // Sliced down to DATA_WIDTH by users; wide enough for any sane operand width.
   localparam logic [MAX_DATA_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

   function automatic int clogb2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) begin
         res = res + 1;
      end
      if (res == 0) begin
         res = 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/fcl_divide_arbiter_if.sv
// Requester-side bus of fcl_divide_arbiter: packed per-requester request and
// operands in, one-hot ack/valid pulses and the shared result out.
interface fcl_divide_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 4
);

   logic [NUM_REQ-1:0]            req_in;
   logic [NUM_REQ*DATA_WIDTH-1:0] numerator_in;
   logic [NUM_REQ*DATA_WIDTH-1:0] denominator_in;
   logic [NUM_REQ-1:0]            ack_out;
   logic [NUM_REQ-1:0]            valid_out;
   logic [DATA_WIDTH-1:0]         quotient_out;
   logic [DATA_WIDTH-1:0]         remainder_out;
   logic                          div_zero_out;
   logic                          busy_out;

   modport master (
      output req_in,
      output numerator_in,
      output denominator_in,
      input  ack_out,
      input  valid_out,
      input  quotient_out,
      input  remainder_out,
      input  div_zero_out,
      input  busy_out
   );

   modport slave (
      input  req_in,
      input  numerator_in,
      input  denominator_in,
      output ack_out,
      output valid_out,
      output quotient_out,
      output remainder_out,
      output div_zero_out,
      output busy_out
   );

endinterface

// File: rtl/fcl_divide.sv
// Sequential restoring divider: one quotient bit per clock, DATA_WIDTH
// iterations after start_in, results valid with a one-cycle done_out pulse.
module fcl_divide
   import fcl_divide_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_in,
   input  logic                  _reset_in,
   input  logic                  start_in,
   input  logic [DATA_WIDTH-1:0] numerator_in,
   input  logic [DATA_WIDTH-1:0] denominator_in,
   output logic [DATA_WIDTH-1:0] quotient_out,
   output logic [DATA_WIDTH-1:0] remainder_out,
   output logic                  done_out
);

   localparam int CNT_W = clogb2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   logic [DATA_WIDTH-1:0] rem_q, rem_d;
   logic [DATA_WIDTH-1:0] quo_q, quo_d;
   logic [DATA_WIDTH-1:0] den_q, den_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  run_q, run_d;
   logic                  done_q, done_d;
   logic [DATA_WIDTH:0]   shifted;
   logic [DATA_WIDTH:0]   diff;

   always_comb begin
      rem_d   = rem_q;
      quo_d   = quo_q;
      den_d   = den_q;
      cnt_d   = cnt_q;
      run_d   = run_q;
      done_d  = 1'b0;
      // Partial remainder is always below den, so one extra bit holds the shift.
      shifted = {rem_q, quo_q[DATA_WIDTH-1]};
      diff    = shifted - {1'b0, den_q};
      if (start_in) begin
         rem_d = '0;
         quo_d = numerator_in;
         den_d = denominator_in;
         cnt_d = CNT_INIT;
         run_d = 1'b1;
      end else if (run_q) begin
         if (!diff[DATA_WIDTH]) begin
            rem_d = diff[DATA_WIDTH-1:0];
            quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
         end else begin
            rem_d = shifted[DATA_WIDTH-1:0];
            quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
         end
         cnt_d = cnt_q - CNT_LAST;
         if (cnt_q == CNT_LAST) begin
            run_d  = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or negedge _reset_in) begin
      if (!_reset_in) begin
         rem_q  <= '0;
         quo_q  <= '0;
         den_q  <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         den_q  <= den_d;
         cnt_q  <= cnt_d;
         run_q  <= run_d;
         done_q <= done_d;
      end
   end

   assign quotient_out  = quo_q;
   assign remainder_out = rem_q;
   assign done_out      = done_q;

endmodule

// File: rtl/fcl_rr_pick.sv
// Combinational round-robin search: first set request at or above ptr_in,
// wrapping past NUM_REQ-1 back to 0.
module fcl_rr_pick
   import fcl_divide_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]          req_in,
   input  logic [clogb2(NUM_REQ)-1:0]  ptr_in,
   output logic [clogb2(NUM_REQ)-1:0]  idx_out,
   output logic                        any_out
);

   localparam int IDX_W = clogb2(NUM_REQ);

   int cand;

   // Walking offsets from far to near lets the nearest hit overwrite the rest.
   always_comb begin
      idx_out = '0;
      any_out = |req_in;
      cand    = 0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         cand = int'(ptr_in) + off;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (req_in[cand]) begin
            idx_out = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/fcl_divide_arbiter.sv
// Shares one fcl_divide core among NUM_REQ requesters with round-robin
// req/ack arbitration; zero denominators are answered without the divider.
module fcl_divide_arbiter
   import fcl_divide_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 4
) (
   input  logic           clk_in,
   input  logic           _reset_in,
   fcl_divide_arbiter_if.slave bus
);

   localparam int IDX_W = clogb2(NUM_REQ);

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [IDX_W-1:0]      ptr_q, ptr_d;
   logic [DATA_WIDTH-1:0] num_q, num_d;
   logic [DATA_WIDTH-1:0] den_q, den_d;
   logic [DATA_WIDTH-1:0] quo_q, quo_d;
   logic [DATA_WIDTH-1:0] rem_q, rem_d;
   logic                  dz_q, dz_d;
   logic [NUM_REQ-1:0]    ack_q, ack_d;
   logic [NUM_REQ-1:0]    valid_q, valid_d;

   logic [IDX_W-1:0]      pick_idx;
   logic                  pick_any;
   logic                  div_start;
   logic                  div_done;
   logic [DATA_WIDTH-1:0] div_quo;
   logic [DATA_WIDTH-1:0] div_rem;

   fcl_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req_in  (bus.req_in),
      .ptr_in  (ptr_q),
      .idx_out (pick_idx),
      .any_out (pick_any)
   );

   fcl_divide #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_div (
      .clk_in         (clk_in),
      ._reset_in      (_reset_in),
      .start_in       (div_start),
      .numerator_in   (num_q),
      .denominator_in (den_q),
      .quotient_out   (div_quo),
      .remainder_out  (div_rem),
      .done_out       (div_done)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      ptr_d     = ptr_q;
      num_d     = num_q;
      den_d     = den_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dz_d      = dz_q;
      ack_d     = '0;
      valid_d   = '0;
      div_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               idx_d           = pick_idx;
               num_d           = bus.numerator_in[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
               den_d           = bus.denominator_in[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
               ack_d[pick_idx] = 1'b1;
               ptr_d           = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
               state_d         = ST_START;
            end
         end
         ST_START: begin
            // The zero test uses the latched denominator; a zero result is
            // loaded here so valid lands one cycle after ack, never starting the divider.
            if (den_q != '0) begin
               div_start = 1'b1;
               state_d   = ST_WAIT;
            end else begin
               quo_d          = DIV_ZERO_QUOTIENT[DATA_WIDTH-1:0];
               rem_d          = num_q;
               dz_d           = 1'b1;
               valid_d[idx_q] = 1'b1;
               state_d        = ST_DONE;
            end
         end
         ST_WAIT: begin
            if (div_done) begin
               quo_d          = div_quo;
               rem_d          = div_rem;
               dz_d           = 1'b0;
               valid_d[idx_q] = 1'b1;
               state_d        = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge _reset_in) begin
      if (!_reset_in) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         ptr_q   <= '0;
         num_q   <= '0;
         den_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
         ack_q   <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         num_q   <= num_d;
         den_q   <= den_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
         ack_q   <= ack_d;
         valid_q <= valid_d;
      end
   end

   assign bus.ack_out       = ack_q;
   assign bus.valid_out     = valid_q;
   assign bus.quotient_out  = quo_q;
   assign bus.remainder_out = rem_q;
   assign bus.div_zero_out  = dz_q;
   assign bus.busy_out      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fcl_divide_arbiter.sv
// Bench for fcl_divide_arbiter: scoreboard of expected results checked on
// every valid pulse, table-driven single transactions and corner sequences.
module tb_fcl_divide_arbiter;

   localparam int DW = 32;
   localparam int NR = 4;

   typedef struct {
      int            id;
      logic [DW-1:0] num;
      logic [DW-1:0] den;
      logic [DW-1:0] q;
      logic [DW-1:0] r;
      logic          dz;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   fcl_divide_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

   fcl_divide_arbiter #(
      .DATA_WIDTH (DW),
      .NUM_REQ    (NR)
   ) dut (
      .clk_in    (clk),
      ._reset_in (rst_n),
      .bus       (bus)
   );

   vec_t sb[$];
   vec_t tbl[9];
   vec_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   ack_cnt[NR];
   int   valid_cnt[NR];
   int   pending[NR];
   int   starts = 0;
   int   valid_total = 0;
   logic div_running = 1'b0;
   logic done_prev = 1'b0;
   logic [NR-1:0] mon_oh;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic push(input int id, input logic [DW-1:0] num, input logic [DW-1:0] den,
                       input logic [DW-1:0] q, input logic [DW-1:0] r, input logic dz);
      vec_t v;
      v.id = id; v.num = num; v.den = den; v.q = q; v.r = r; v.dz = dz;
      sb.push_back(v);
   endtask

   task automatic set_ops(input int id, input logic [DW-1:0] num, input logic [DW-1:0] den);
      bus.numerator_in[id*DW +: DW]   = num;
      bus.denominator_in[id*DW +: DW] = den;
   endtask

   function automatic bit pending_any();
      for (int i = 0; i < NR; i++) if (pending[i] > 0) return 1'b1;
      return 1'b0;
   endfunction

   // Requester agent: keeps req while transactions remain, drops it on the last ack.
   task automatic serve(input int max_cyc);
      int n;
      n = 0;
      while ((pending_any() || sb.size() != 0 || bus.busy_out) && n < max_cyc) begin
         @(negedge clk);
         n++;
         for (int i = 0; i < NR; i++) begin
            if (bus.ack_out[i]) begin
               pending[i]--;
               if (pending[i] <= 0) bus.req_in[i] = 1'b0;
            end
         end
      end
      chk("serve_timeout", DW'(n >= max_cyc), '0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ack"},   DW'(bus.ack_out),      '0);
      chk({tag, "_valid"}, DW'(bus.valid_out),    '0);
      chk({tag, "_quot"},  bus.quotient_out,      '0);
      chk({tag, "_rem"},   bus.remainder_out,     '0);
      chk({tag, "_dz"},    DW'(bus.div_zero_out), '0);
      chk({tag, "_busy"},  DW'(bus.busy_out),     '0);
   endtask

   task automatic run_one(input vec_t v);
      int            s0;
      int            lat;
      logic [NR-1:0] oh;
      oh       = '0;
      oh[v.id] = 1'b1;
      s0       = starts;
      set_ops(v.id, v.num, v.den);
      push(v.id, v.num, v.den, v.q, v.r, v.dz);
      bus.req_in[v.id] = 1'b1;
      @(negedge clk);
      chk("ack_t1", DW'(bus.ack_out), DW'(oh));
      bus.req_in[v.id] = 1'b0;
      lat = 1;
      while (bus.valid_out == '0 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("valid_seen", DW'(bus.valid_out), DW'(oh));
      if (v.den == '0) chk("zero_valid_t2", DW'(lat), DW'(2));
      @(negedge clk);
      chk("busy_fall", DW'(bus.busy_out), '0);
      chk("start_count", DW'(starts - s0), DW'(v.den != '0));
      $display("txn req=%0d %0d/%0d latency=%0d", v.id, v.num, v.den, lat);
   endtask

   // Monitor: counts handshakes, guards divider start protocol, checks results.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            div_running = 1'b0;
            done_prev   = 1'b0;
         end else begin
            if (dut.div_start) begin
               starts++;
               chk("start_overlap", DW'(div_running), '0);
               div_running = 1'b1;
            end
            if (dut.div_done) div_running = 1'b0;
            if (bus.ack_out != '0) begin
               chk("ack_onehot", DW'($countones(bus.ack_out)), DW'(1));
               for (int i = 0; i < NR; i++) if (bus.ack_out[i]) ack_cnt[i]++;
            end
            if (bus.valid_out != '0) begin
               valid_total++;
               for (int i = 0; i < NR; i++) if (bus.valid_out[i]) valid_cnt[i]++;
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_valid actual=%b required=none", bus.valid_out);
               end else begin
                  mon_e          = sb.pop_front();
                  mon_oh         = '0;
                  mon_oh[mon_e.id] = 1'b1;
                  chk("valid_id",  DW'(bus.valid_out),    DW'(mon_oh));
                  chk("quotient",  bus.quotient_out,      mon_e.q);
                  chk("remainder", bus.remainder_out,     mon_e.r);
                  chk("div_zero",  DW'(bus.div_zero_out), DW'(mon_e.dz));
                  if (!mon_e.dz) chk("valid_after_done", DW'(done_prev), DW'(1));
               end
            end
            done_prev = dut.div_done;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int a0, v0, a2, v2, vt;
      bus.req_in         = '0;
      bus.numerator_in   = '0;
      bus.denominator_in = '0;
      for (int i = 0; i < NR; i++) begin
         pending[i] = 0; ack_cnt[i] = 0; valid_cnt[i] = 0;
      end
      tbl[0] = '{1, 32'd100,        32'd7,          32'd14,         32'd2,   1'b0};
      tbl[1] = '{3, 32'd55,         32'd0,          32'hFFFFFFFF,   32'd55,  1'b1};
      tbl[2] = '{2, 32'd1000,       32'd33,         32'd30,         32'd10,  1'b0};
      tbl[3] = '{0, 32'd5,          32'd9,          32'd0,          32'd5,   1'b0};
      tbl[4] = '{1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,   1'b0};
      tbl[5] = '{3, 32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2,   1'b0};
      tbl[6] = '{0, 32'd0,          32'd5,          32'd0,          32'd0,   1'b0};
      tbl[7] = '{2, 32'd12345678,   32'd1000,       32'd12345,      32'd678, 1'b0};
      tbl[8] = '{1, 32'd0,          32'd0,          32'hFFFFFFFF,   32'd0,   1'b1};

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Round robin from a fresh pointer: 0 then 2.
      set_ops(0, 32'd20, 32'd6);
      set_ops(2, 32'd81, 32'd9);
      push(0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0);
      push(2, 32'd81, 32'd9, 32'd9, 32'd0, 1'b0);
      pending[0] = 1; pending[2] = 1;
      bus.req_in = 4'b0101;
      serve(300);
      $display("txn rr pair done");

      // All four at once with pointer at 3: order 3, 0, 1, 2.
      set_ops(3, 32'd1000, 32'd10);
      set_ops(0, 32'd77,   32'd5);
      set_ops(1, 32'd64,   32'd3);
      set_ops(2, 32'd1000, 32'd37);
      push(3, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
      push(0, 32'd77,   32'd5,  32'd15,  32'd2, 1'b0);
      push(1, 32'd64,   32'd3,  32'd21,  32'd1, 1'b0);
      push(2, 32'd1000, 32'd37, 32'd27,  32'd1, 1'b0);
      for (int i = 0; i < NR; i++) pending[i] = 1;
      bus.req_in = 4'b1111;
      serve(600);
      $display("txn rr all four done");

      for (int k = 0; k < 9; k++) run_one(tbl[k]);

      // Back-to-back from requester 0 holding req.
      a0 = ack_cnt[0];
      v0 = valid_cnt[0];
      set_ops(0, 32'hFFFFFFFF, 32'd1);
      for (int k = 0; k < 4; k++) push(0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
      pending[0] = 4;
      bus.req_in[0] = 1'b1;
      serve(600);
      chk("b2b_acks",   DW'(ack_cnt[0] - a0),   DW'(4));
      chk("b2b_valids", DW'(valid_cnt[0] - v0), DW'(4));
      $display("txn back-to-back x4 done");

      // Requester 2 pulses req during requester 1's WAIT and withdraws.
      a2 = ack_cnt[2];
      v2 = valid_cnt[2];
      set_ops(1, 32'd1000, 32'd33);
      push(1, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0);
      pending[1] = 1;
      bus.req_in[1] = 1'b1;
      @(negedge clk);
      chk("wd_ack1", DW'(bus.ack_out), DW'(4'b0010));
      bus.req_in[1] = 1'b0;
      pending[1] = 0;
      repeat (5) @(negedge clk);
      set_ops(2, 32'd9, 32'd3);
      bus.req_in[2] = 1'b1;
      repeat (3) @(negedge clk);
      bus.req_in[2] = 1'b0;
      serve(300);
      repeat (5) @(negedge clk);
      chk("wd_no_ack2",   DW'(ack_cnt[2] - a2),   '0);
      chk("wd_no_valid2", DW'(valid_cnt[2] - v2), '0);
      $display("txn withdrawal done");

      // Reset during WAIT aborts requester 2's transaction.
      set_ops(2, 32'd500, 32'd7);
      bus.req_in[2] = 1'b1;
      @(negedge clk);
      chk("rst_ack2", DW'(bus.ack_out), DW'(4'b0100));
      bus.req_in[2] = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      vt = valid_total;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("midrst_no_valid", DW'(valid_total - vt), '0);

      // Pointer back at 0: requester 0 wins over 3, then 3 is served.
      set_ops(0, 32'd9,   32'd2);
      set_ops(3, 32'd200, 32'd9);
      push(0, 32'd9,   32'd2, 32'd4,  32'd1, 1'b0);
      push(3, 32'd200, 32'd9, 32'd22, 32'd2, 1'b0);
      pending[0] = 1; pending[3] = 1;
      bus.req_in = 4'b1001;
      serve(300);
      $display("txn post-reset pair done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
